alu_packet_parser: RTL



---
 rtl/alu_packet_parser_if.sv | 26 ++
 rtl/alu_packet_parser.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_packet_parser_if.sv
// Byte-in / operand-word-out bus of the ALU packet parser.
// The slave modport is the parser side; master is the surrounding environment.
interface alu_packet_parser_if #(
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned OperandWidth = 32
);
  logic [DataWidth-1:0]    data_i;
  logic                    valid_i;
  logic                    ready_o;
  logic [DataWidth-1:0]    opcode_o;
  logic [OperandWidth-1:0] operand_o;
  logic                    valid_o;
  logic                    ready_i;
  logic                    last_o;
  logic                    err_o;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, opcode_o, operand_o, valid_o, last_o, err_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, opcode_o, operand_o, valid_o, last_o, err_o
  );
endinterface

// File: rtl/alu_packet_parser.sv
// Assembles ALU command packets (opcode, reserved, len16 LE, LE operand words) from a byte stream.
// Optional ALU_PARSER_OPCODE_CHECK_EN: only opcodes 0x00..0x02 are accepted, others drop the packet.
module alu_packet_parser #(
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned OperandWidth = 32
) (
  input logic              clk_i,
  input logic              reset_ni,
  alu_packet_parser_if.slave bus
);

  typedef enum logic [2:0] {
    ST_OP, ST_RSV, ST_LEN_LO, ST_LEN_HI, ST_OPERAND, ST_DROP
  } state_t;

  state_t                              r_state, w_state_nxt;
  logic [DataWidth-1:0]                r_pend_op;
  logic                                r_bad_op;
  logic [DataWidth-1:0]                r_len_lo;
  logic [DataWidth-1:0]                r_opcode;
  logic [OperandWidth-DataWidth-1:0]   r_asm;
  logic [1:0]                          r_byte_cnt;
  logic [15:0]                         r_remaining;
  logic [OperandWidth-1:0]             r_operand;
  logic                                r_valid;
  logic                                r_last;
  logic                                r_err;

  logic        w_ready;
  logic        w_byte_xfer;
  logic        w_word_xfer;
  logic        w_op_bad;
  logic [15:0] w_len;
  logic        w_len_bad;
  logic        w_rem_last;
  logic        w_word_done;

`ifdef ALU_PARSER_OPCODE_CHECK_EN
  assign w_op_bad = (bus.data_i > 8'h02);
`else
  assign w_op_bad = 1'b0;
`endif

  // Only the final byte of a word can stall, and only while the output slot is still occupied.
  assign w_ready     = !((r_state == ST_OPERAND) && (r_byte_cnt == 2'd3) && r_valid && !bus.ready_i);
  assign w_byte_xfer = bus.valid_i && w_ready;
  assign w_word_xfer = r_valid && bus.ready_i;
  assign w_len       = {bus.data_i, r_len_lo};
  assign w_len_bad   = (w_len < 16'd8) || (w_len[1:0] != 2'b00) || r_bad_op;
  assign w_rem_last  = (r_remaining == 16'd1);
  assign w_word_done = w_byte_xfer && (r_state == ST_OPERAND) && (r_byte_cnt == 2'd3);

  assign bus.ready_o   = w_ready;
  assign bus.opcode_o  = r_opcode;
  assign bus.operand_o = r_operand;
  assign bus.valid_o   = r_valid;
  assign bus.last_o    = r_last;
  assign bus.err_o     = r_err;

  always_comb begin
    w_state_nxt = r_state;
    if (w_byte_xfer) begin
      case (r_state)
        ST_OP:      w_state_nxt = ST_RSV;
        ST_RSV:     w_state_nxt = ST_LEN_LO;
        ST_LEN_LO:  w_state_nxt = ST_LEN_HI;
        ST_LEN_HI: begin
          if (!w_len_bad)            w_state_nxt = ST_OPERAND;
          else if (w_len > 16'd4)    w_state_nxt = ST_DROP;
          else                       w_state_nxt = ST_OP;
        end
        ST_OPERAND: if (w_rem_last) w_state_nxt = ST_OP;
        ST_DROP:    if (w_rem_last) w_state_nxt = ST_OP;
        default:    w_state_nxt = ST_OP;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= ST_OP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_pend_op   <= '0;
      r_bad_op    <= 1'b0;
      r_len_lo    <= '0;
      r_opcode    <= '0;
      r_asm       <= '0;
      r_byte_cnt  <= '0;
      r_remaining <= '0;
      r_operand   <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;

      if (w_word_done) begin
        r_operand <= {bus.data_i, r_asm};
        r_valid   <= 1'b1;
        r_last    <= w_rem_last;
      end else if (w_word_xfer) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end

      if (w_byte_xfer) begin
        case (r_state)
          ST_OP: begin
            r_pend_op <= bus.data_i;
            r_bad_op  <= w_op_bad;
          end
          ST_LEN_LO: r_len_lo <= bus.data_i;
          ST_LEN_HI: begin
            r_remaining <= w_len - 16'd4;
            r_byte_cnt  <= '0;
            if (w_len_bad) begin
              r_err <= 1'b1;
            end else begin
              r_opcode <= r_pend_op;
            end
          end
          ST_OPERAND: begin
            r_remaining <= r_remaining - 16'd1;
            r_byte_cnt  <= r_byte_cnt + 2'd1;
            if (r_byte_cnt != 2'd3) begin
              r_asm[r_byte_cnt*DataWidth +: DataWidth] <= bus.data_i;
            end
          end
          ST_DROP: r_remaining <= r_remaining - 16'd1;
          default: ;
        endcase
      end
    end
  end

endmodule
